// File: rtl/lc3_wb_pkg.sv
// Shared definitions for the LC-3 writeback stage.
//   - W_Control source-select encodings
//   - writeback FSM state type
//   - NZP reset value (Z set)
package lc3_wb_pkg;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC   = 2'd2;
  localparam logic [1:0] WB_NONE = 2'd3;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  localparam logic [2:0] NZP_RST = 3'b010;

endpackage

// File: rtl/lc3_nzp_gen.sv
// Combinational NZP condition-code generator, shared with the branch unit.
// Ports:
//   data  in  WIDTH  value being written
//   nzp   out 3      {N,Z,P}; exactly one bit is set
module lc3_nzp_gen #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] data,
  output logic [2:0]       nzp
);

  logic n_flag;
  logic z_flag;

  assign n_flag = data[WIDTH-1];
  assign z_flag = (data == '0);
  assign nzp    = {n_flag, z_flag, ~n_flag & ~z_flag};

endmodule

// File: rtl/lc3_writeback.sv
// LC-3 writeback stage: producer side of the register-file write port.
// Accepts one result per handshake, waits for memory data on loads, emits a
// one-cycle write strobe (en/dr/DR_in) and updates the NZP flags.
// Ports:
//   clk, rst                      clock, async active-high reset
//   in_valid / in_ready           result handshake from execute
//   W_Control, dr_in, cc_en       source select, destination, flag-update enable
//   aluout, pcout                 candidate results sampled on accept
//   memout, mem_valid             load data and its valid
//   flush                         abort a pending load
//   en, dr, DR_in                 register-file write strobe, address, data
//   psr                           NZP flags {N,Z,P}
//   pend_valid, pend_dr           outstanding load, for decode RAW stalls
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | ready for a new result
// WAIT_MEM | load accepted, waiting for mem_valid or flush
module lc3_writeback
  import lc3_wb_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        W_Control,
  input  logic [REG_AW-1:0] dr_in,
  input  logic              cc_en,
  input  logic [WIDTH-1:0]  aluout,
  input  logic [WIDTH-1:0]  pcout,
  input  logic [WIDTH-1:0]  memout,
  input  logic              mem_valid,
  input  logic              flush,
  output logic              en,
  output logic [REG_AW-1:0] dr,
  output logic [WIDTH-1:0]  DR_in,
  output logic [2:0]        psr,
  output logic              pend_valid,
  output logic [REG_AW-1:0] pend_dr
);

  wb_state_t         state_q, state_d;
  logic              pend_cc_q;
  logic              load_accept;
  logic              wr;
  logic [REG_AW-1:0] wr_dr;
  logic [WIDTH-1:0]  wr_data;
  logic              wr_cc;
  logic [2:0]        wr_nzp;

  // Handshake outputs decode the state register only.
  assign in_ready   = (state_q == IDLE);
  assign pend_valid = (state_q == WAIT_MEM);

  always_comb begin
    state_d     = state_q;
    load_accept = 1'b0;
    wr          = 1'b0;
    wr_dr       = dr_in;
    wr_data     = aluout;
    wr_cc       = cc_en;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          unique case (W_Control)
            WB_ALU: wr = 1'b1;
            WB_PC: begin
              wr      = 1'b1;
              wr_data = pcout;
            end
            WB_MEM: begin
              load_accept = 1'b1;
              state_d     = WAIT_MEM;
            end
            default: ;
          endcase
        end
      end
      WAIT_MEM: begin
        wr_dr   = pend_dr;
        wr_data = memout;
        wr_cc   = pend_cc_q;
        // flush wins over a same-cycle mem_valid
        if (flush) begin
          state_d = IDLE;
        end else if (mem_valid) begin
          wr      = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  lc3_nzp_gen #(.WIDTH(WIDTH)) u_nzp (
    .data (wr_data),
    .nzp  (wr_nzp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_dr   <= '0;
      pend_cc_q <= 1'b0;
      en        <= 1'b0;
      dr        <= '0;
      DR_in     <= '0;
      psr       <= NZP_RST;
    end else begin
      state_q <= state_d;
      en      <= wr;
      if (load_accept) begin
        pend_dr   <= dr_in;
        pend_cc_q <= cc_en;
      end
      if (wr) begin
        dr    <= wr_dr;
        DR_in <= wr_data;
        if (wr_cc) psr <= wr_nzp;
      end
    end
  end

endmodule

// File: tb/tb_lc3_writeback.sv
module tb_lc3_writeback;
  import lc3_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  W_Control;
  logic [2:0]  dr_in;
  logic        cc_en;
  logic [15:0] aluout, pcout, memout;
  logic        mem_valid, flush;
  logic        en;
  logic [2:0]  dr;
  logic [15:0] DR_in;
  logic [2:0]  psr;
  logic        pend_valid;
  logic [2:0]  pend_dr;

  typedef struct packed {
    logic [2:0]  dr;
    logic [15:0] data;
    logic [2:0]  psr;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        got;
  logic [2:0] model_psr;
  int         checks   = 0;
  int         failures = 0;

  lc3_writeback #(.WIDTH(16), .REG_AW(3)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .W_Control(W_Control), .dr_in(dr_in), .cc_en(cc_en),
    .aluout(aluout), .pcout(pcout), .memout(memout),
    .mem_valid(mem_valid), .flush(flush),
    .en(en), .dr(dr), .DR_in(DR_in), .psr(psr),
    .pend_valid(pend_valid), .pend_dr(pend_dr)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] nzp_of(input logic [15:0] d);
    if (d[15])       return 3'b100;
    else if (d == 0) return 3'b010;
    else             return 3'b001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Push the write the model expects from this stimulus.
  task automatic expect_wr(input logic [2:0] d, input logic [15:0] data, input logic cc);
    wr_t e;
    if (cc) model_psr = nzp_of(data);
    e.dr = d; e.data = data; e.psr = model_psr;
    exp_q.push_back(e);
  endtask

  // Present one result for one clock edge, then sample #1 after the edge.
  task automatic accept(input logic [1:0] wc, input logic [2:0] d, input logic cc,
                        input logic [15:0] alu, input logic [15:0] pc);
    in_valid = 1'b1; W_Control = wc; dr_in = d; cc_en = cc; aluout = alu; pcout = pc;
    if (wc == WB_ALU) expect_wr(d, alu, cc);
    if (wc == WB_PC)  expect_wr(d, pc, cc);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Scoreboard: every en pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {13'd0, dr, DR_in}, 32'hFFFF_FFFF);
      end else begin
        got = exp_q.pop_front();
        chk("wr_dr",   {29'd0, dr},    {29'd0, got.dr});
        chk("wr_data", {16'd0, DR_in}, {16'd0, got.data});
        chk("wr_psr",  {29'd0, psr},   {29'd0, got.psr});
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 0; W_Control = WB_NONE; dr_in = 0; cc_en = 0;
    aluout = 0; pcout = 0; memout = 0; mem_valid = 0; flush = 0;
    model_psr = NZP_RST;
    repeat (2) @(posedge clk); #1;
    chk("rst_en",         {31'd0, en},         0);
    chk("rst_dr",         {29'd0, dr},         0);
    chk("rst_DR_in",      {16'd0, DR_in},      0);
    chk("rst_psr",        {29'd0, psr},        32'd2);
    chk("rst_in_ready",   {31'd0, in_ready},   1);
    chk("rst_pend_valid", {31'd0, pend_valid}, 0);
    chk("rst_pend_dr",    {29'd0, pend_dr},    0);
    rst = 1'b0;
    tick();

    // Single ALU write with negative result
    accept(WB_ALU, 3'd3, 1'b1, 16'h8001, 16'h0);
    chk("alu_en",    {31'd0, en},    1);
    chk("alu_dr",    {29'd0, dr},    3);
    chk("alu_data",  {16'd0, DR_in}, 32'h8001);
    chk("alu_psr",   {29'd0, psr},   32'd4);
    tick();
    chk("alu_en_drop", {31'd0, en},  0);
    chk("alu_hold_dr", {29'd0, dr},  3);

    // Back-to-back: PC, ALU zero (cc), ALU 5 (no cc)
    accept(WB_PC,  3'd7, 1'b0, 16'h0, 16'h3000);
    accept(WB_ALU, 3'd1, 1'b1, 16'h0000, 16'h0);
    chk("b2b_psr_zero", {29'd0, psr}, 32'd2);
    accept(WB_ALU, 3'd2, 1'b0, 16'h0005, 16'h0);
    chk("b2b_en3",      {31'd0, en},  1);
    chk("b2b_psr_kept", {29'd0, psr}, 32'd2);
    tick();
    chk("b2b_en_drop", {31'd0, en}, 0);

    // Load to R4; mem_valid in the accept cycle must be ignored
    mem_valid = 1'b1; memout = 16'hFFFF;
    accept(WB_MEM, 3'd4, 1'b1, 16'h0, 16'h0);
    mem_valid = 1'b0;
    chk("ld_in_ready",   {31'd0, in_ready},   0);
    chk("ld_pend_valid", {31'd0, pend_valid}, 1);
    chk("ld_pend_dr",    {29'd0, pend_dr},    4);
    chk("ld_no_early_en",{31'd0, en},         0);
    tick();
    tick();
    chk("ld_still_wait", {31'd0, pend_valid}, 1);
    mem_valid = 1'b1; memout = 16'h0007;
    expect_wr(3'd4, 16'h0007, 1'b1);
    tick();
    mem_valid = 1'b0;
    chk("ld_en",         {31'd0, en},         1);
    chk("ld_data",       {16'd0, DR_in},      32'h0007);
    chk("ld_psr",        {29'd0, psr},        32'd1);
    chk("ld_in_ready1",  {31'd0, in_ready},   1);
    chk("ld_pend_drop",  {31'd0, pend_valid}, 0);
    tick();

    // Load to R5 flushed with simultaneous mem_valid
    accept(WB_MEM, 3'd5, 1'b1, 16'h0, 16'h0);
    flush = 1'b1; mem_valid = 1'b1; memout = 16'h8000;
    tick();
    flush = 1'b0; mem_valid = 1'b0;
    chk("fl_en",       {31'd0, en},       0);
    chk("fl_psr",      {29'd0, psr},      {29'd0, model_psr});
    chk("fl_in_ready", {31'd0, in_ready}, 1);
    tick();
    chk("fl_en_after", {31'd0, en},       0);

    // flush in IDLE does not disturb an accept
    flush = 1'b1;
    accept(WB_ALU, 3'd6, 1'b1, 16'h8000, 16'h0);
    flush = 1'b0;
    chk("idle_flush_en",  {31'd0, en},  1);
    chk("idle_flush_psr", {29'd0, psr}, 32'd4);
    tick();

    // Async reset while waiting on a load
    accept(WB_MEM, 3'd6, 1'b1, 16'h0, 16'h0);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready",   {31'd0, in_ready},   1);
    chk("arst_pend_valid", {31'd0, pend_valid}, 0);
    chk("arst_pend_dr",    {29'd0, pend_dr},    0);
    chk("arst_psr",        {29'd0, psr},        32'd2);
    chk("arst_dr",         {29'd0, dr},         0);
    chk("arst_DR_in",      {16'd0, DR_in},      0);
    model_psr = NZP_RST;
    mem_valid = 1'b1; memout = 16'h1234;
    tick();
    mem_valid = 1'b0;
    rst = 1'b0;
    tick();
    chk("arst_no_write", {31'd0, en}, 0);

    // W_Control = none: no write, flags untouched
    accept(WB_ALU, 3'd2, 1'b1, 16'h9000, 16'h0);
    tick();
    accept(WB_NONE, 3'd3, 1'b1, 16'h0000, 16'h0);
    chk("none_en",  {31'd0, en},  0);
    chk("none_psr", {29'd0, psr}, 32'd4);
    chk("none_dr",  {29'd0, dr},  2);

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lc3_writeback.md
# lc3_writeback

Writeback stage of the LC-3 controller datapath: the producer side of the register-file write port. It accepts one completed instruction result per handshake, selects the result source, and waits for memory data on loads. It then drives a one-cycle write strobe (`en`/`dr`/`DR_in`) into the register file and updates the NZP condition codes. It also exports the pending load destination so decode can stall on a RAW hazard.

## Interface
Parameters:
- `WIDTH`, 16, datapath width
- `REG_AW`, 3, register address width (8 registers)

Ports:
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  result presented by execute
- `in_ready`  out  1  writeback can accept; high exactly when state is IDLE
- `W_Control`  in  2  source select: 0 = aluout, 1 = memout (load), 2 = pcout, 3 = no write
- `dr_in`  in  REG_AW  destination register
- `cc_en`  in  1  update NZP with the written value
- `aluout`, `pcout`  in  WIDTH  candidate results, sampled on accept
- `memout`  in  WIDTH  load data, sampled when `mem_valid` is high in WAIT_MEM
- `mem_valid`  in  1  load data valid
- `flush`  in  1  abort a pending load
- `en`  out  1  register-file write enable, one-cycle pulse
- `dr`  out  REG_AW  write address
- `DR_in`  out  WIDTH  write data
- `psr`  out  3  NZP flags {N,Z,P}
- `pend_valid`  out  1  a load is outstanding
- `pend_dr`  out  REG_AW  destination of the outstanding load

## Operation
- Accept condition: `in_valid & in_ready`.
- States:
  - IDLE: `in_ready`=1.
  - WAIT_MEM: `in_ready`=0, `pend_valid`=1.
- Accept in IDLE:
  - W_Control 0 or 2: register the selected operand into `DR_in`, `dr_in` into `dr`, and set `en`=1 for the next cycle. State stays IDLE.
  - W_Control 1: capture `dr_in` into `pend_dr` and the `cc_en` flag into the pending flag. Go to WAIT_MEM. No write yet.
  - W_Control 3: no write, NZP unchanged, state stays IDLE.
- WAIT_MEM with `mem_valid`=1: register `memout` into `DR_in` and `pend_dr` into `dr`, set `en`=1 for the next cycle, and return to IDLE. `pend_valid` drops in the same edge.
- WAIT_MEM with `flush`=1: return to IDLE with no write. `flush` has priority over a simultaneous `mem_valid`.
- `flush` in IDLE: no effect. An accept in the same cycle proceeds normally.
- `mem_valid` outside WAIT_MEM: ignored.
- NZP update, on the same edge that sets `en`=1 and only when the captured `cc_en` is 1:
  - N = data[15]
  - Z = (data == 0)
  - P = ~N & ~Z
  - Exactly one flag is set at all times.
- `en` is high for exactly one cycle per write. `dr`/`DR_in` hold their last value while `en`=0.

## Timing
- Reset values: `en`=0, `dr`=0, `DR_in`=0, `psr`=3'b010 (Z), state IDLE, `in_ready`=1, `pend_valid`=0, `pend_dr`=0.
- Reset mid-load abandons the load with no write.
- ALU/PC result:
  - Accept at edge t gives `en`, `dr`, `DR_in` and updated `psr` visible after edge t.
  - The register file commits at edge t+1.
  - Throughput is one result per cycle.
- Load:
  - Accept at edge t gives `pend_valid`=1 after t.
  - `mem_valid` sampled at edge t+k gives `en`=1 after t+k, and `in_ready`=1 in the same cycle.
  - Minimum k=1, so `mem_valid` in the accept cycle is not used.
- Back-to-back: an accept in the cycle where `en` is high is legal and produces a write pulse on the following cycle.
- `in_ready` and `pend_valid` are pure decodes of the state register, with no combinational path from inputs.

## Structure
- Shared package `lc3_wb_pkg`:
  - W_Control encodings `WB_ALU`, `WB_MEM`, `WB_PC`, `WB_NONE`
  - state enum {IDLE, WAIT_MEM}
  - NZP reset constant `NZP_RST`=3'b010
- Sub-module `lc3_nzp_gen`: combinational, WIDTH-bit data to 3-bit NZP. It is reused by the branch unit.
- The top level holds the FSM, the pending registers and the output registers.

## Test plan
- Reset, then ALU accept with dr_in=3, aluout=16'h8001, cc_en=1 -> next cycle en=1, dr=3, DR_in=16'h8001, psr=3'b100; en=0 the cycle after.
- Three consecutive accepts (PC 16'h3000 to R7, ALU 0 to R1 with cc_en=1, ALU 5 to R2 with cc_en=0) -> three consecutive en pulses, psr=010 after the second and still 010 after the third.
- Load to R4 with mem_valid 3 cycles later and memout=16'h0007, cc_en=1:
  - in_ready=0 and pend_valid=1, pend_dr=4 while waiting
  - then en=1, DR_in=16'h0007, psr=001
  - in_ready=1 in the same cycle
- Load to R5, then flush and mem_valid asserted in the same cycle -> no en pulse, psr unchanged, IDLE next cycle.
- Assert rst asynchronously during WAIT_MEM -> outputs return to reset values immediately with no write; W_Control=3 accept -> no en, psr unchanged.
